// File: rtl/jk_count_ctrl.sv
// jk_count_ctrl: control stage ahead of the JK flip-flop bank of the up/down counter.
// Synchronises and debounces the up/down buttons, tracks the count direction,
// prescales count steps, handles parallel load, and builds per-bit j/k vectors
// from the bank's fed-back q so every bank edge is exactly one hold, step or load.
//
//   state | meaning
//   ------+-------------------------------------------------
//   IDLE  | no direction selected; prescaler held, j=k=0
//   UP    | count up by one on every tick
//   DOWN  | count down by one on every tick
module jk_count_ctrl #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_btn,
    input  logic             dn_btn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             dir,
    output logic             tick,
    output logic             tc
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       btn_raw;
    logic [1:0]       sync1, sync2;
    logic [1:0]       filt, filt_d;
    logic [DW-1:0]    dbc [2];
    logic [1:0]       press;
    logic [PW-1:0]    pcnt;
    logic             load_pend;
    logic [WIDTH-1:0] load_reg;
    logic [WIDTH-1:0] t_up, t_dn;
    logic             at_limit;
    logic             blocked;

    // index 0 = up button, index 1 = down button
    assign btn_raw = {dn_btn, up_btn};

    // two-flop synchroniser for both raw buttons
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // debounce: a level is accepted after DEBOUNCE consecutive differing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt   <= '0;
            filt_d <= '0;
            for (int b = 0; b < 2; b++) dbc[b] <= '0;
        end else begin
            filt_d <= filt;
            for (int b = 0; b < 2; b++) begin
                if (sync2[b] != filt[b]) begin
                    if (dbc[b] == DW'(DEBOUNCE - 1)) begin
                        filt[b] <= ~filt[b];
                        dbc[b]  <= '0;
                    end else begin
                        dbc[b] <= dbc[b] + 1'b1;
                    end
                end else begin
                    dbc[b] <= '0;
                end
            end
        end
    end

    assign press = filt & ~filt_d;

    // direction state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // direction next state: a press selects its direction, simultaneous presses park in IDLE
    always_comb begin
        state_d = state_q;
        if (press[0] && press[1]) state_d = IDLE;
        else if (press[0])        state_d = UP;
        else if (press[1])        state_d = DOWN;
    end

    assign dir = (state_q == UP);

    // step prescaler; tick is registered on the wrap from PRESCALE-1 to 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else if (!en || state_q == IDLE) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else if (pcnt == PW'(PRESCALE - 1)) begin
            pcnt <= '0;
            tick <= 1'b1;
        end else begin
            pcnt <= pcnt + 1'b1;
            tick <= 1'b0;
        end
    end

    // load capture; a repeated request while pending just replaces the value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_pend <= 1'b0;
            load_reg  <= '0;
        end else if (load) begin
            load_pend <= 1'b1;
            load_reg  <= load_val;
        end else begin
            load_pend <= 1'b0;
        end
    end

    // toggle enables: bit i flips when all lower bits are ones (up) or zeros (down)
    always_comb begin
        t_up = '0;
        t_dn = '0;
        for (int i = 0; i < WIDTH; i++) begin
            logic [WIDTH-1:0] m;
            m       = (WIDTH'(1) << i) - WIDTH'(1);
            t_up[i] = ((q & m) == m);
            t_dn[i] = ((q & m) == '0);
        end
    end

    assign at_limit = ((state_q == UP) && (&q)) || ((state_q == DOWN) && !(|q));
    assign blocked  = sat_mode && at_limit;

    // j/k select: a pending load wins, then a step on tick, otherwise hold
    always_comb begin
        j = '0;
        k = '0;
        if (load_pend) begin
            j = load_reg;
            k = ~load_reg;
        end else if (tick && !blocked) begin
            if (state_q == UP) begin
                j = t_up;
                k = t_up;
            end else if (state_q == DOWN) begin
                j = t_dn;
                k = t_dn;
            end
        end
    end

    // terminal count: flagged after any step tick taken at the direction's limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tc <= 1'b0;
        else       tc <= tick && !load_pend && at_limit;
    end

endmodule

// File: doc/jk_count_ctrl.md
Name: jk_count_ctrl

Overview:
- Control stage directly upstream of the JK flip-flop bank in the up/down counter.
- Synchronises and debounces raw up/down buttons, runs a direction FSM and a step prescaler, and handles parallel load.
- Generates per-bit j/k vectors from the bank's fed-back q, so each bank clock edge performs exactly one hold, step or load.

Parameters:
- WIDTH, 8, counter width (number of JK flip-flops driven).
- PRESCALE, 4, clk cycles per count step; legal range ≥1.
- DEBOUNCE, 3, consecutive stable synchronised samples required before a button level is accepted; legal range ≥1.

Ports:
- clk  in  1  clock; shared with the JK bank.
- reset  in  1  asynchronous, active-high.
- en  in  1  count enable; 0 freezes the prescaler and suppresses steps.
- up_btn  in  1  raw asynchronous up button.
- dn_btn  in  1  raw asynchronous down button.
- load  in  1  synchronous one-cycle load request.
- load_val  in  WIDTH  value to load, sampled when load=1.
- sat_mode  in  1  1 = saturate at limits, 0 = wrap.
- q  in  WIDTH  current JK bank outputs (feedback).
- j  out  WIDTH  J inputs to the bank.
- k  out  WIDTH  K inputs to the bank.
- dir  out  1  1 when FSM is in UP, else 0.
- tick  out  1  registered one-cycle step strobe.
- tc  out  1  registered one-cycle terminal-count pulse.

Behaviour:
- Reset: clears sync flops, filtered levels, debounce counters, FSM (IDLE), prescaler, tick, tc, load_pend and load_reg. Consequently dir=0, j=0, k=0 while reset is asserted and on the first cycle after release.
- Button path, per button:
  - 2-flop synchroniser.
  - Debounce counter increments each cycle the synchronised value differs from the filtered level and clears when they are equal.
  - When the counter reaches DEBOUNCE, the filtered level flips and the counter clears.
  - Rising edge of the filtered level is detected with a registered compare and gives a one-cycle press pulse.
- Direction FSM, states IDLE/UP/DOWN:
  - up press → UP; dn press → DOWN, from any state.
  - Both presses in the same cycle → IDLE.
  - Releases have no effect.
- Prescaler:
  - Counts only while en=1 and state≠IDLE.
  - tick is registered: asserts for exactly one cycle when the count wraps from PRESCALE-1 to 0.
  - en=0 or IDLE forces the count to 0 and tick to 0.
  - With PRESCALE=1, tick stays high every cycle while counting.
- Load:
  - load=1 captures load_val into load_reg and sets load_pend.
  - Next cycle: j=load_reg, k=~load_reg, tick is ignored for j/k, and load_pend clears at that edge.
  - load=1 while load_pend=1 overwrites load_reg; pend stays set.
- Step (tick=1, no load_pend), with t[i] = toggle enable:
  - UP: t[i]=1 iff q[i-1:0] are all ones; t[0]=1.
  - DOWN: t[i]=1 iff q[i-1:0] are all zeros; t[0]=1.
  - Output j=k=t.
- Hold: otherwise j=k=0.
- j/k are combinational from registered state and q. The bank updates on the following edge; one step per tick.
- Saturation, when sat_mode=1:
  - UP with q all ones, or DOWN with q=0 → j=k=0 on the tick.
  - With sat_mode=0 the step wraps (FF→00, 00→FF).
- tc: set for one cycle on the edge after any tick where q was at the limit for the current direction (all ones in UP, zero in DOWN), whether wrapped or blocked. Load cycles never raise tc.
- Reset mid-operation: everything returns to reset values immediately and any pending load is discarded.

Test Plan:
- Reset asserted, then released with buttons low → j=k=0, dir=0, tick=0, tc=0 for ≥20 cycles.
- up_btn pulsed high for 2 cycles → no FSM change. up_btn held high → dir=1 within 2+DEBOUNCE+1=6 cycles, then tick every 4 cycles. With the bank attached, q steps 00→01→02→03.
- q=0x7F, UP, tick → j=k=0xFF; next q=0x80. q=0xFF, UP, sat_mode=0 → q=0x00 and tc pulses once. Same with sat_mode=1 → j=k=0, q stays 0xFF, tc pulses.
- dn press while in UP with q=0x00, sat_mode=0 → dir=0, next tick gives q=0xFF and a tc pulse. up and dn presses debounced on the same cycle → IDLE, tick stops.
- load=1, load_val=0xA5, coinciding with tick → next cycle j=0xA5, k=0x5A, q becomes 0xA5, no step that cycle, tc=0. en=0 → tick never asserts and q holds.
- Reset asserted mid-count (q=0x42, load pending) → FSM IDLE, j=k=0, and the pending load is not applied after release.
